led_stretch: RTL and testbench

Downstream output stage for the board status LED. It takes the one-bit, cycle-level in-range flag produced by the compare stage and converts each rising edge into a pulse long enough to see on an LED. It enforces a minimum off gap between pulses, counts accepted events, and flags events it had to drop.

---
 rtl/led_stretch_if.sv | 13 +
 rtl/led_stretch.sv | 103 ++++++++++
 tb/tb_led_stretch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/led_stretch_if.sv
// led_stretch_if: flag/clear inputs and LED/status outputs of the LED pulse stretcher
interface led_stretch_if #(
  parameter int CNT_W = 8
);
  logic FLAG_IN;
  logic CNT_CLR;
  logic LED_OUT;
  logic BUSY;
  logic [CNT_W-1:0] EVT_CNT;
  logic EVT_DROP;
  modport master (output FLAG_IN, CNT_CLR, input LED_OUT, BUSY, EVT_CNT, EVT_DROP);
  modport slave (input FLAG_IN, CNT_CLR, output LED_OUT, BUSY, EVT_CNT, EVT_DROP);
endinterface

// File: rtl/led_stretch.sv
// led_stretch: stretches each rising edge of the in-range flag into a visible LED pulse,
// enforces an off gap between pulses, counts accepted edges and flags dropped ones.
// Optional LED blinking during the hold is enabled by defining LED_STRETCH_BLINK_EN.
module led_stretch #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int BLINK_HALF  = 2,
  parameter int CNT_W       = 8
) (
  input logic CLK,
  input logic RST_X,
  led_stretch_if.slave bus
);
  localparam int TMAX = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW = $clog2(TMAX);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic flag_q, rise, acc, drop;
  if (HOLD_CYCLES < 2 || GAP_CYCLES < 1 || BLINK_HALF < 1 || CNT_W < 1) begin : g_bad_param
    $error("led_stretch: illegal parameter value");
  end
  // edge detector history, FSM state and shared hold/gap timer
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      flag_q <= 1'b0;
      state <= IDLE;
      timer <= '0;
    end else begin
      flag_q <= bus.FLAG_IN;
      state <= state_d;
      timer <= timer_d;
    end
  end
  // next state: a rise in HOLD retriggers even when the timer expires, a rise in GAP is dropped
  always_comb begin
    rise = bus.FLAG_IN & ~flag_q;
    state_d = state;
    timer_d = timer;
    acc = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_d = HOLD;
          timer_d = HOLD_LD;
          acc = 1'b1;
        end
      end
      HOLD: begin
        if (rise) begin
          timer_d = HOLD_LD;
          acc = 1'b1;
        end else if (timer == '0) begin
          state_d = GAP;
          timer_d = GAP_LD;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      GAP: begin
        drop = rise;
        if (timer == '0) state_d = IDLE;
        else timer_d = timer - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // status outputs lag the state by one cycle; clear beats a simultaneous increment
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      bus.BUSY <= 1'b0;
      bus.EVT_DROP <= 1'b0;
      bus.EVT_CNT <= '0;
    end else begin
      bus.BUSY <= state != IDLE;
      bus.EVT_DROP <= drop;
      bus.EVT_CNT <= bus.CNT_CLR ? '0 : (acc && ~&bus.EVT_CNT) ? bus.EVT_CNT + CNT_W'(1) : bus.EVT_CNT;
    end
  end
`ifdef LED_STRETCH_BLINK_EN
  localparam int PW = $clog2(2 * BLINK_HALF);
  logic [PW-1:0] ph;
  // blink phase restarts on every accepted edge so the LED always opens with an on half
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) ph <= '0;
    else ph <= acc ? '0 : (state != HOLD) ? ph : (ph == PW'(2 * BLINK_HALF - 1)) ? '0 : ph + PW'(1);
  end
  // LED blinks while holding and is dark everywhere else
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) bus.LED_OUT <= 1'b0;
    else bus.LED_OUT <= (state == HOLD) && (ph < PW'(BLINK_HALF));
  end
`else
  // LED is steady on for the whole hold
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) bus.LED_OUT <= 1'b0;
    else bus.LED_OUT <= state == HOLD;
  end
`endif
endmodule

// File: tb/tb_led_stretch.sv
// tb_led_stretch: directed and random checks of led_stretch against a timeline model
module tb_led_stretch;
  localparam int H = 8;
  localparam int G = 2;
  localparam int BH = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef LED_STRETCH_BLINK_EN
  localparam int LH_ONE = 4;
  localparam int LH_RT = 7;
`else
  localparam int LH_ONE = 8;
  localparam int LH_RT = 13;
`endif
  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;
  led_stretch_if #(.CNT_W(CW)) bus ();
  led_stretch #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BLINK_HALF(BH), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_X(RST_X), .bus(bus)
  );
  int n_chk = 0, n_err = 0;
  int t = 0, a = -1000, cnt = 0;
  bit prev = 1'b0, e_led = 1'b0, e_busy = 1'b0, e_drop = 1'b0;
  int lh, bh, dh;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("led", 32'(bus.LED_OUT), 32'(e_led));
    chk("busy", 32'(bus.BUSY), 32'(e_busy));
    chk("drop", 32'(bus.EVT_DROP), 32'(e_drop));
    chk("cnt", 32'(bus.EVT_CNT), 32'(cnt));
  endtask
  task automatic model_reset();
    a = -1000;
    prev = 1'b0;
    cnt = 0;
    e_led = 1'b0;
    e_busy = 1'b0;
    e_drop = 1'b0;
  endtask
  // one clock: apply inputs, advance the timeline model, check everything after the edge
  task automatic step(input bit f, input bit c);
    int d;
    bit rise, acc;
    bus.FLAG_IN = f;
    bus.CNT_CLR = c;
    @(posedge CLK);
    t++;
    d = t - a;
    e_led = d >= 1 && d <= H;
`ifdef LED_STRETCH_BLINK_EN
    e_led = e_led && ((d - 1) % (2 * BH)) < BH;
`endif
    e_busy = d >= 1 && d <= H + G;
    rise = f && !prev;
    prev = f;
    acc = rise && (d <= H || d > H + G);
    e_drop = rise && !acc;
    if (acc) a = t;
    if (c) cnt = 0;
    else if (acc && cnt < CMAX) cnt++;
    #1;
    check_all();
    lh += int'(bus.LED_OUT);
    bh += int'(bus.BUSY);
    dh += int'(bus.EVT_DROP);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask
  initial begin
    int c0;
    bit f;
    bus.FLAG_IN = 1'b1;
    bus.CNT_CLR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    model_reset();
    check_all();
    RST_X = 1'b1;
    lh = 0; bh = 0; dh = 0;
    step(1'b1, 1'b0);
    chk("rst_first_cnt", 32'(bus.EVT_CNT), 32'd1);
    idle(12);
    chk("rst_led_len", lh, LH_ONE);
    lh = 0; bh = 0; dh = 0;
    step(1'b1, 1'b0);
    idle(14);
    chk("pulse_led_len", lh, LH_ONE);
    chk("pulse_busy_len", bh, H + G);
    chk("pulse_drops", dh, 0);
    chk("pulse_cnt", 32'(bus.EVT_CNT), 32'd2);
    lh = 0; bh = 0; dh = 0;
    c0 = cnt;
    step(1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b0);
    idle(15);
    chk("retrig_led_len", lh, LH_RT);
    chk("retrig_cnt", 32'(bus.EVT_CNT), 32'(c0 + 2));
    c0 = cnt;
    step(1'b1, 1'b0);
    idle(8);
    step(1'b1, 1'b0);
    chk("gap_drop", 32'(bus.EVT_DROP), 32'd1);
    chk("gap_led", 32'(bus.LED_OUT), 32'd0);
    chk("gap_cnt", 32'(bus.EVT_CNT), 32'(c0 + 1));
    step(1'b1, 1'b0);
    chk("gap_drop_once", 32'(bus.EVT_DROP), 32'd0);
    step(1'b1, 1'b0);
    chk("gap_idle", 32'(bus.BUSY), 32'd0);
    chk("gap_no_redetect", 32'(bus.EVT_CNT), 32'(c0 + 1));
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    chk("sat_cnt", 32'(bus.EVT_CNT), 32'd15);
    step(1'b1, 1'b1);
    chk("clr_with_rise", 32'(bus.EVT_CNT), 32'd0);
    idle(12);
    step(1'b1, 1'b0);
    idle(3);
    #3;
    RST_X = 1'b0;
    #1;
    model_reset();
    chk("async_led", 32'(bus.LED_OUT), 32'd0);
    check_all();
    #2;
    RST_X = 1'b1;
    f = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) f = ~f;
      step(f, $urandom_range(0, 39) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
